cp0_exc_ctrl: RTL

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

---
 rtl/cp0_exc_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: minimal MIPS-style CP0 exception controller.
// Handles syscall, external interrupt and eret. Holds Status, Cause and EPC.
// Optional timer (Count reg 9 / Compare reg 11 driving Cause.IP7) is built
// only when the macro CP0_TIMER_EN is defined.
module cp0_exc_ctrl #(
  parameter logic [31:0] VECTOR_ADDR = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        sc,
  input  logic        irq,
  input  logic        eret,
  input  logic        mtc0,
  input  logic        mfc0,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        stall,
  output logic        exl
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VECTOR = 2'd1,
    RETURN = 2'd2
  } state_t;

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;

  state_t      state_reg, state_next;
  logic        ie_reg;
  logic        exl_reg;
  logic [4:0]  exc_code_reg;
  logic        ip2_reg;
  logic        ip7;
  logic [31:0] epc_reg;

  logic        take_eret;
  logic        take_exc;
  logic [4:0]  exc_code_next;
  logic        wr_en;
  logic [31:0] count_rd;
  logic [31:0] compare_rd;

  // CP0 writes are accepted only while the pipeline is not being redirected.
  assign wr_en = mtc0 && (state_reg == IDLE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Event arbitration, next state and redirect outputs.
  always_comb begin
    state_next    = state_reg;
    take_eret     = 1'b0;
    take_exc      = 1'b0;
    exc_code_next = exc_code_reg;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    stall         = 1'b0;
    case (state_reg)
      IDLE: begin
        // eret (only meaningful with EXL set) beats syscall beats interrupt.
        if (eret && exl_reg) begin
          take_eret  = 1'b1;
          state_next = RETURN;
        end else if (sc) begin
          take_exc      = 1'b1;
          exc_code_next = 5'd8;
          state_next    = VECTOR;
        end else if (ie_reg && !exl_reg && (ip2_reg || ip7)) begin
          take_exc      = 1'b1;
          exc_code_next = 5'd0;
          state_next    = VECTOR;
        end
      end
      VECTOR: begin
        redirect    = 1'b1;
        redirect_pc = VECTOR_ADDR;
        stall       = 1'b1;
        state_next  = IDLE;
      end
      RETURN: begin
        redirect    = 1'b1;
        redirect_pc = epc_reg;
        stall       = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status, Cause and EPC; exception updates override a same-cycle mtc0.
  always_ff @(posedge clock) begin
    if (reset) begin
      ie_reg       <= 1'b0;
      exl_reg      <= 1'b0;
      exc_code_reg <= 5'd0;
      ip2_reg      <= 1'b0;
      epc_reg      <= 32'h0;
    end else begin
      ip2_reg <= irq;
      if (wr_en) begin
        case (cp0_addr)
          ADDR_STATUS: begin
            ie_reg  <= w_data[0];
            exl_reg <= w_data[1];
          end
          ADDR_EPC: epc_reg <= w_data;
          default: ;
        endcase
      end
      if (take_eret) begin
        exl_reg <= 1'b0;
      end else if (take_exc) begin
        epc_reg      <= pc;
        exc_code_reg <= exc_code_next;
        exl_reg      <= 1'b1;
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        ip7_reg;

  // Free-running Count, Compare match raising IP7, Compare write clearing it.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg   <= 32'h0;
      compare_reg <= 32'hFFFF_FFFF;
      ip7_reg     <= 1'b0;
    end else begin
      if (wr_en && cp0_addr == ADDR_COUNT) count_reg <= w_data;
      else                                 count_reg <= count_reg + 32'd1;
      if (count_reg == compare_reg) ip7_reg <= 1'b1;
      if (wr_en && cp0_addr == ADDR_COMPARE) begin
        compare_reg <= w_data;
        ip7_reg     <= 1'b0;
      end
    end
  end

  assign ip7        = ip7_reg;
  assign count_rd   = count_reg;
  assign compare_rd = compare_reg;
`else
  assign ip7        = 1'b0;
  assign count_rd   = 32'h0;
  assign compare_rd = 32'h0;
`endif

  // Combinational mfc0 read mux; anything unmapped reads zero.
  always_comb begin
    r_data = 32'h0;
    if (mfc0) begin
      case (cp0_addr)
        ADDR_COUNT:   r_data = count_rd;
        ADDR_COMPARE: r_data = compare_rd;
        ADDR_STATUS:  r_data = {30'h0, exl_reg, ie_reg};
        ADDR_CAUSE:   r_data = {16'h0, ip7, 4'h0, ip2_reg, 3'h0, exc_code_reg, 2'b00};
        ADDR_EPC:     r_data = epc_reg;
        default:      r_data = 32'h0;
      endcase
    end
  end

  assign exl = exl_reg;

endmodule
